// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush and optional EX/MEM + writeback operand forwarding.
// Optional feature: define ID_EX_FORWARDING_EN to enable forwarding; undefined, operands come straight from the stored register data.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic [3:0]            InAluOp,
  input  logic [DATA_WIDTH-1:0] InPc,
  input  logic [DATA_WIDTH-1:0] InRs1Data,
  input  logic [DATA_WIDTH-1:0] InRs2Data,
  input  logic [DATA_WIDTH-1:0] InImm,
  input  logic [4:0]            InRs1Addr,
  input  logic [4:0]            InRs2Addr,
  input  logic [4:0]            InRdAddr,
  input  logic                  InUseImm,
  input  logic                  InUsePc,
  input  logic                  InRegWrite,
  input  logic                  InIsBranch,
  input  logic [4:0]            MemRdAddr,
  input  logic                  MemRegWrite,
  input  logic [DATA_WIDTH-1:0] MemResult,
  input  logic [4:0]            WbRdAddr,
  input  logic                  WbRegWrite,
  input  logic [DATA_WIDTH-1:0] WbResult,
  output logic                  OutValid,
  output logic [3:0]            OutAluOp,
  output logic [DATA_WIDTH-1:0] OutOpA,
  output logic [DATA_WIDTH-1:0] OutOpB,
  output logic [DATA_WIDTH-1:0] OutStoreData,
  output logic [DATA_WIDTH-1:0] OutPc,
  output logic [4:0]            OutRdAddr,
  output logic                  OutRegWrite,
  output logic                  OutIsBranch
);

  logic                  r_valid;
  logic [3:0]            r_alu_op;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [4:0]            r_rs1_addr;
  logic [4:0]            r_rs2_addr;
  logic [4:0]            r_rd_addr;
  logic                  r_use_imm;
  logic                  r_use_pc;
  logic                  r_reg_write;
  logic                  r_is_branch;

  logic [DATA_WIDTH-1:0] w_fwd_rs1;
  logic [DATA_WIDTH-1:0] w_fwd_rs2;

`ifdef ID_EX_FORWARDING_EN
  // MEM is the younger producer, so it wins over WB; x0 is hardwired and never forwards.
  assign w_fwd_rs1 = (MemRegWrite && r_rs1_addr != 5'd0 && MemRdAddr == r_rs1_addr) ? MemResult :
                     (WbRegWrite  && r_rs1_addr != 5'd0 && WbRdAddr  == r_rs1_addr) ? WbResult  :
                     r_rs1_data;
  assign w_fwd_rs2 = (MemRegWrite && r_rs2_addr != 5'd0 && MemRdAddr == r_rs2_addr) ? MemResult :
                     (WbRegWrite  && r_rs2_addr != 5'd0 && WbRdAddr  == r_rs2_addr) ? WbResult  :
                     r_rs2_data;
`else
  logic w_unused;
  assign w_fwd_rs1 = r_rs1_data;
  assign w_fwd_rs2 = r_rs2_data;
  assign w_unused  = ^{MemRdAddr, MemRegWrite, MemResult, WbRdAddr, WbRegWrite, WbResult,
                       r_rs1_addr, r_rs2_addr};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid     <= 1'b0;
      r_alu_op    <= '0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_use_imm   <= 1'b0;
      r_use_pc    <= 1'b0;
      r_reg_write <= 1'b0;
      r_is_branch <= 1'b0;
    end else if (Flush) begin
      r_valid     <= 1'b0;
      r_alu_op    <= '0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_use_imm   <= 1'b0;
      r_use_pc    <= 1'b0;
      r_reg_write <= 1'b0;
      r_is_branch <= 1'b0;
    end else if (Stall) begin
      // Refresh operands so a result retiring during the stall is not lost.
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end else begin
      r_valid     <= InValid;
      r_alu_op    <= InAluOp;
      r_pc        <= InPc;
      r_rs1_data  <= InRs1Data;
      r_rs2_data  <= InRs2Data;
      r_imm       <= InImm;
      r_rs1_addr  <= InRs1Addr;
      r_rs2_addr  <= InRs2Addr;
      r_rd_addr   <= InRdAddr;
      r_use_imm   <= InUseImm;
      r_use_pc    <= InUsePc;
      r_reg_write <= InRegWrite & InValid;
      r_is_branch <= InIsBranch;
    end
  end

  assign OutOpA       = r_use_pc  ? r_pc  : w_fwd_rs1;
  assign OutOpB       = r_use_imm ? r_imm : w_fwd_rs2;
  assign OutStoreData = w_fwd_rs2;
  assign OutValid     = r_valid;
  assign OutAluOp     = r_alu_op;
  assign OutPc        = r_pc;
  assign OutRdAddr    = r_rd_addr;
  assign OutRegWrite  = r_reg_write;
  assign OutIsBranch  = r_is_branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed spot checks plus randomized traffic against a field-level model.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, InValid, Stall, Flush;
  logic [3:0]  InAluOp;
  logic [31:0] InPc, InRs1Data, InRs2Data, InImm;
  logic [4:0]  InRs1Addr, InRs2Addr, InRdAddr;
  logic        InUseImm, InUsePc, InRegWrite, InIsBranch;
  logic [4:0]  MemRdAddr, WbRdAddr;
  logic        MemRegWrite, WbRegWrite;
  logic [31:0] MemResult, WbResult;
  logic        OutValid, OutRegWrite, OutIsBranch;
  logic [3:0]  OutAluOp;
  logic [31:0] OutOpA, OutOpB, OutStoreData, OutPc;
  logic [4:0]  OutRdAddr;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  id_ex_stage #(.DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .Stall(Stall), .Flush(Flush),
    .InAluOp(InAluOp), .InPc(InPc), .InRs1Data(InRs1Data), .InRs2Data(InRs2Data), .InImm(InImm),
    .InRs1Addr(InRs1Addr), .InRs2Addr(InRs2Addr), .InRdAddr(InRdAddr),
    .InUseImm(InUseImm), .InUsePc(InUsePc), .InRegWrite(InRegWrite), .InIsBranch(InIsBranch),
    .MemRdAddr(MemRdAddr), .MemRegWrite(MemRegWrite), .MemResult(MemResult),
    .WbRdAddr(WbRdAddr), .WbRegWrite(WbRegWrite), .WbResult(WbResult),
    .OutValid(OutValid), .OutAluOp(OutAluOp), .OutOpA(OutOpA), .OutOpB(OutOpB),
    .OutStoreData(OutStoreData), .OutPc(OutPc), .OutRdAddr(OutRdAddr),
    .OutRegWrite(OutRegWrite), .OutIsBranch(OutIsBranch)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit        valid;
    bit [3:0]  alu_op;
    bit [31:0] pc, rs1_data, rs2_data, imm;
    bit [4:0]  rs1_addr, rs2_addr, rd_addr;
    bit        use_imm, use_pc, reg_write, is_branch;
  } slot_t;

  slot_t m = '{default: '0};
  const slot_t bubble = '{default: '0};

  // Value an operand register would read right now, given the live forward ports.
  function automatic bit [31:0] fwd(input bit [4:0] addr, input bit [31:0] data);
    if (!FWD || addr == 5'd0)                     return data;
    if (MemRegWrite === 1'b1 && MemRdAddr == addr) return MemResult;
    if (WbRegWrite  === 1'b1 && WbRdAddr  == addr) return WbResult;
    return data;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) m = bubble;
    else if (Flush) m = bubble;
    else if (Stall) begin
      m.rs1_data = fwd(m.rs1_addr, m.rs1_data);
      m.rs2_data = fwd(m.rs2_addr, m.rs2_data);
    end else begin
      m.valid = InValid;      m.alu_op = InAluOp;       m.pc = InPc;
      m.rs1_data = InRs1Data; m.rs2_data = InRs2Data;   m.imm = InImm;
      m.rs1_addr = InRs1Addr; m.rs2_addr = InRs2Addr;   m.rd_addr = InRdAddr;
      m.use_imm = InUseImm;   m.use_pc = InUsePc;
      m.reg_write = InRegWrite && InValid;              m.is_branch = InIsBranch;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      #1;
      check("valid",    OutValid,     m.valid);
      check("alu_op",   OutAluOp,     m.alu_op);
      check("pc",       OutPc,        m.pc);
      check("rd_addr",  OutRdAddr,    m.rd_addr);
      check("regwrite", OutRegWrite,  m.reg_write);
      check("branch",   OutIsBranch,  m.is_branch);
      check("op_a",     OutOpA,  m.use_pc  ? m.pc  : fwd(m.rs1_addr, m.rs1_data));
      check("op_b",     OutOpB,  m.use_imm ? m.imm : fwd(m.rs2_addr, m.rs2_data));
      check("store",    OutStoreData, fwd(m.rs2_addr, m.rs2_data));
    end
  end

  task automatic idle();
    InValid = 0; Stall = 0; Flush = 0; InAluOp = 0;
    InPc = 0; InRs1Data = 0; InRs2Data = 0; InImm = 0;
    InRs1Addr = 0; InRs2Addr = 0; InRdAddr = 0;
    InUseImm = 0; InUsePc = 0; InRegWrite = 0; InIsBranch = 0;
    MemRdAddr = 0; MemRegWrite = 0; MemResult = 0;
    WbRdAddr = 0; WbRegWrite = 0; WbResult = 0;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge Clk);
    // Reset state, with a forward port aimed at x0.
    MemRdAddr = 0; MemRegWrite = 1; MemResult = 32'h55;
    #3;
    check("rst_valid", OutValid, 1'b0);
    check("rst_pc",    OutPc,    32'h0);
    check("rst_op_a",  OutOpA,   32'h0);
    check("rst_op_b",  OutOpB,   32'h0);
    @(negedge Clk); idle(); Reset = 1'b0;

    // Operand select: PC and immediate paths, store data still from rs2.
    @(negedge Clk); idle();
    InValid = 1; InUsePc = 1; InPc = 32'h100; InUseImm = 1; InImm = 32'hFFFF_FFFC;
    InRs2Data = 32'd7; InAluOp = 4'd3; InRdAddr = 5'd4; InRegWrite = 1;
    @(negedge Clk); idle(); #3;
    check("sel_op_a",  OutOpA,       32'h100);
    check("sel_op_b",  OutOpB,       32'hFFFF_FFFC);
    check("sel_store", OutStoreData, 32'd7);
    check("sel_valid", OutValid,     1'b1);
    check("sel_rw",    OutRegWrite,  1'b1);

    // Forward priority: MEM over WB, then WB alone.
    @(negedge Clk); idle(); InValid = 1; InRs1Addr = 5'd5; InRs1Data = 32'd1;
    @(negedge Clk); idle();
    MemRdAddr = 5'd5; MemRegWrite = 1; MemResult = 32'hAA;
    WbRdAddr  = 5'd5; WbRegWrite  = 1; WbResult  = 32'hBB;
    #3 check("prio_mem", OutOpA, FWD ? 32'hAA : 32'd1);
    MemRegWrite = 0;
    #1 check("prio_wb",  OutOpA, FWD ? 32'hBB : 32'd1);

    // x0 never forwards.
    @(negedge Clk); idle(); InValid = 1; InRs2Addr = 0; InRs2Data = 0; InUseImm = 0;
    @(negedge Clk); idle(); MemRdAddr = 0; MemRegWrite = 1; MemResult = 32'h55;
    #3;
    check("x0_op_b",  OutOpB,       32'h0);
    check("x0_store", OutStoreData, 32'h0);

    // Stall refresh: WB result present only during the first stall cycle.
    @(negedge Clk); idle(); InValid = 1; InRs1Addr = 5'd3; InRs1Data = 32'h11;
    @(negedge Clk); idle(); Stall = 1; WbRdAddr = 5'd3; WbRegWrite = 1; WbResult = 32'h1234;
    @(negedge Clk); idle(); Stall = 1;
    #3 check("stall_2nd",  OutOpA, FWD ? 32'h1234 : 32'h11);
    @(negedge Clk); idle();
    #3 check("stall_rel",  OutOpA, FWD ? 32'h1234 : 32'h11);

    // Flush wins over stall on the same edge.
    @(negedge Clk); idle(); InValid = 1; InRegWrite = 1; InRdAddr = 5'd9; InIsBranch = 1;
    @(negedge Clk); Stall = 1; Flush = 1;
    @(negedge Clk); idle(); #3;
    check("flush_valid", OutValid,    1'b0);
    check("flush_rw",    OutRegWrite, 1'b0);
    check("flush_rd",    OutRdAddr,   5'd0);
    check("flush_br",    OutIsBranch, 1'b0);

    // RegWrite gated by valid.
    @(negedge Clk); idle(); InValid = 0; InRegWrite = 1; InRdAddr = 5'd6;
    @(negedge Clk); idle(); #3;
    check("inv_rw",    OutRegWrite, 1'b0);
    check("inv_rd",    OutRdAddr,   5'd6);

    // Async reset mid-cycle, overriding a pending stall+flush; capture resumes after release.
    @(negedge Clk); idle(); InValid = 1; InPc = 32'h40;
    @(negedge Clk); idle(); Stall = 1; Flush = 1;
    #3 check("pre_rst_valid", OutValid, 1'b1);
    Reset = 1'b1;
    #1;
    check("async_valid", OutValid, 1'b0);
    check("async_pc",    OutPc,    32'h0);
    @(negedge Clk); idle(); Reset = 1'b0; InValid = 1; InPc = 32'h80;
    @(negedge Clk); idle(); #3;
    check("post_rst_valid", OutValid, 1'b1);
    check("post_rst_pc",    OutPc,    32'h80);

    // Randomized traffic; small address space so forwarding hits often.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      Reset       = ($urandom_range(0, 99) < 2);
      Stall       = ($urandom_range(0, 99) < 25);
      Flush       = ($urandom_range(0, 99) < 10);
      InValid     = 1'($urandom);
      InAluOp     = 4'($urandom);
      InPc        = $urandom;
      InRs1Data   = $urandom;
      InRs2Data   = $urandom;
      InImm       = $urandom;
      InRs1Addr   = 5'($urandom_range(0, 7));
      InRs2Addr   = 5'($urandom_range(0, 7));
      InRdAddr    = 5'($urandom);
      InUseImm    = 1'($urandom);
      InUsePc     = 1'($urandom);
      InRegWrite  = 1'($urandom);
      InIsBranch  = 1'($urandom);
      MemRdAddr   = 5'($urandom_range(0, 7));
      MemRegWrite = 1'($urandom);
      MemResult   = $urandom;
      WbRdAddr    = 5'($urandom_range(0, 7));
      WbRegWrite  = 1'($urandom);
      WbResult    = $urandom;
    end

    @(negedge Clk); idle(); Reset = 1'b0;
    #3 cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
